// File: rtl/axi_rd_arb_pkg.sv
// Shared AXI read-arbiter definitions: response/burst encodings, FSM states
// and the round-robin pointer helper.
package axi_rd_arb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } arb_state_t;

    // Index following idx in a ring of n requesters.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/axi_rd_arb_rr_pick.sv
// Combinational round-robin priority encoder: returns the first asserted
// request at or after ptr, wrapping modulo N.
module axi_rd_arb_rr_pick #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         hit
);

    int best_off;
    int off;

    // Each requester's distance from ptr around the ring; the smallest wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant    = '0;
        hit      = 1'b0;
        best_off = N;
        off      = 0;
        for (int j = 0; j < N; j++) begin
            // NOTE: blocking assignments here, so off/best_off update in loop order within the cycle.
            off = (j + N - int'(ptr)) % N;
            if (req[j] && (off < best_off)) begin
                best_off = off;
                grant    = W'(j);
                hit      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arb.sv
// N-master to 1-slave AXI4 read arbiter (AR + R), round-robin, one burst in
// flight. Optional R watchdog enabled by defining AXI_RD_ARB_TIMEOUT_EN.
module axi_rd_arb
    import axi_rd_arb_pkg::*;
#(
    parameter int N_MST   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_MST-1:0]           s_ar_valid_i,
    input  logic [N_MST*ADDR_W-1:0]    s_ar_addr_i,
    input  logic [N_MST*8-1:0]         s_ar_len_i,
    input  logic [N_MST*3-1:0]         s_ar_size_i,
    input  logic [N_MST*2-1:0]         s_ar_burst_i,
    output logic [N_MST-1:0]           s_ar_ready_o,
    output logic [N_MST-1:0]           s_r_valid_o,
    output logic [DATA_W-1:0]          s_r_data_o,
    output logic [1:0]                 s_r_resp_o,
    output logic                       s_r_last_o,
    input  logic [N_MST-1:0]           s_r_ready_i,
    output logic                       m_ar_valid_o,
    output logic [ADDR_W-1:0]          m_ar_addr_o,
    output logic [ID_W-1:0]            m_ar_id_o,
    output logic [7:0]                 m_ar_len_o,
    output logic [2:0]                 m_ar_size_o,
    output logic [1:0]                 m_ar_burst_o,
    input  logic                       m_ar_ready_i,
    input  logic                       m_r_valid_i,
    input  logic [DATA_W-1:0]          m_r_data_i,
    input  logic [1:0]                 m_r_resp_i,
    input  logic                       m_r_last_i,
    input  logic [ID_W-1:0]            m_r_id_i,
    output logic                       m_r_ready_o,
    output logic                       busy_o,
    output logic [$clog2(N_MST)-1:0]   grant_o
);

    localparam int GW = $clog2(N_MST);

    arb_state_t       state;
    logic [GW-1:0]    grant;
    logic [GW-1:0]    rr_ptr;
    logic [GW-1:0]    pick_grant;
    logic             pick_hit;

    logic [ADDR_W-1:0] ar_addr  [N_MST];
    logic [7:0]        ar_len   [N_MST];
    logic [2:0]        ar_size  [N_MST];
    logic [1:0]        ar_burst [N_MST];

    logic ar_valid_sel;
    logic ar_fire;
    logic r_hs;
    logic to_fire;
    logic done;

    // Only one burst is ever outstanding, so the returned ID carries no routing information.
    logic unused_r_id;
    assign unused_r_id = ^m_r_id_i;

    for (genvar k = 0; k < N_MST; k++) begin : g_unpack
        assign ar_addr[k]  = s_ar_addr_i[k*ADDR_W +: ADDR_W];
        assign ar_len[k]   = s_ar_len_i[k*8 +: 8];
        assign ar_size[k]  = s_ar_size_i[k*3 +: 3];
        assign ar_burst[k] = s_ar_burst_i[k*2 +: 2];
    end

    axi_rd_arb_rr_pick #(
        .N (N_MST),
        .W (GW)
    ) u_rr_pick (
        .req   (s_ar_valid_i),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .hit   (pick_hit)
    );

    assign ar_valid_sel = s_ar_valid_i[grant];
    assign ar_fire      = (state == ST_ADDR) && ar_valid_sel && m_ar_ready_i;
    assign r_hs         = (state == ST_DATA) && !to_fire && m_r_valid_i && s_r_ready_i[grant];

`ifdef AXI_RD_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;

    assign to_fire = (state == ST_DATA) && (to_cnt == TO_W'(TIMEOUT));

    // Counts R-idle cycles in DATA; holds at TIMEOUT while the error beat waits.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state != ST_DATA)) begin
            to_cnt <= '0;
        end else if (r_hs) begin
            to_cnt <= '0;
        end else if (!to_fire) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign done = to_fire ? s_r_ready_i[grant] : (r_hs && m_r_last_i);
`else
    assign to_fire = 1'b0;
    assign done    = r_hs && m_r_last_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: non-blocking for all sequential state, so every flop samples pre-edge values.
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_hit) begin
                        grant <= pick_grant;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (ar_fire) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (done) begin
                        state  <= ST_IDLE;
                        rr_ptr <= GW'(next_idx(int'(grant), N_MST));
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // AR fields come straight from the granted master, which must hold them until ready.
    always_comb begin
        m_ar_valid_o = 1'b0;
        m_ar_addr_o  = '0;
        m_ar_id_o    = '0;
        m_ar_len_o   = '0;
        m_ar_size_o  = '0;
        m_ar_burst_o = '0;
        s_ar_ready_o = '0;
        s_r_valid_o  = '0;
        s_r_data_o   = '0;
        s_r_resp_o   = RESP_OKAY;
        s_r_last_o   = 1'b0;
        m_r_ready_o  = 1'b0;
        case (state)
            ST_ADDR: begin
                m_ar_valid_o        = ar_valid_sel;
                m_ar_addr_o         = ar_addr[grant];
                m_ar_id_o           = ID_W'(grant);
                m_ar_len_o          = ar_len[grant];
                m_ar_size_o         = ar_size[grant];
                m_ar_burst_o        = ar_burst[grant];
                s_ar_ready_o[grant] = m_ar_ready_i;
            end
            ST_DATA: begin
                if (to_fire) begin
                    s_r_valid_o[grant] = 1'b1;
                    s_r_resp_o         = RESP_SLVERR;
                    s_r_last_o         = 1'b1;
                end else begin
                    s_r_valid_o[grant] = m_r_valid_i;
                    s_r_data_o         = m_r_data_i;
                    s_r_resp_o         = m_r_resp_i;
                    s_r_last_o         = m_r_last_i;
                    m_r_ready_o        = s_r_ready_i[grant];
                end
            end
            default: ;
        endcase
    end

    assign busy_o  = (state != ST_IDLE);
    assign grant_o = grant;

endmodule

// File: doc/axi_rd_arb.md
Name: axi_rd_arb

Overview:
- N-master to 1-slave AXI4 read-channel arbiter (AR + R).
- Lets IFU, LSU and future requesters share the core's single io_master read port.
- Round-robin grant, one outstanding transaction at a time, burst-aware (completes on rlast).
- Sits between the fetch/load units and the top-level io_master_ar*/r* pins.

Parameters:
N_MST, 2, number of requesting masters (>=2, <=16)
ADDR_W, 32, address width
DATA_W, 32, data width
ID_W, 4, AXI ID width; issued arid = grant index (N_MST <= 2**ID_W)
TIMEOUT, 1024, idle cycles in DATA before watchdog fires (optional feature only)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
s_ar_valid_i  in  N_MST  per-master AR valid
s_ar_addr_i  in  N_MST*ADDR_W  packed, master k at [k*ADDR_W +: ADDR_W]
s_ar_len_i  in  N_MST*8  packed burst length
s_ar_size_i  in  N_MST*3  packed burst size
s_ar_burst_i  in  N_MST*2  packed burst type
s_ar_ready_o  out  N_MST  per-master AR ready
s_r_valid_o  out  N_MST  per-master R valid (one-hot or zero)
s_r_data_o  out  DATA_W  R data, broadcast
s_r_resp_o  out  2  R resp, broadcast
s_r_last_o  out  1  R last, broadcast
s_r_ready_i  in  N_MST  per-master R ready
m_ar_valid_o  out  1  downstream AR valid
m_ar_addr_o  out  ADDR_W  downstream AR addr
m_ar_id_o  out  ID_W  grant index
m_ar_len_o  out  8  burst length
m_ar_size_o  out  3  burst size
m_ar_burst_o  out  2  burst type
m_ar_ready_i  in  1  downstream AR ready
m_r_valid_i  in  1  downstream R valid
m_r_data_i  in  DATA_W  downstream R data
m_r_resp_i  in  2  downstream R resp
m_r_last_i  in  1  downstream R last
m_r_id_i  in  ID_W  downstream R id
m_r_ready_o  out  1  downstream R ready
busy_o  out  1  state != IDLE
grant_o  out  $clog2(N_MST)  current/last grant index

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant=0.
- Reset values: all valid/ready outputs 0, busy_o=0, grant_o=0.
- Reset mid-transaction abandons it; no beats are forwarded after reset.
- IDLE:
  - Search s_ar_valid_i starting at rr_ptr, wrapping modulo N_MST.
  - First hit is registered as grant; go to ADDR next cycle (1-cycle arbitration latency).
  - No request: stay in IDLE.
  - No AR/R outputs asserted in IDLE.
- ADDR:
  - m_ar_* driven combinationally from the granted master's inputs.
  - m_ar_id_o = grant zero-extended to ID_W.
  - s_ar_ready_o[grant] = m_ar_ready_i; all others 0.
  - On m_ar_valid_o && m_ar_ready_i: go to DATA.
  - Masters must hold AR stable until ready (AXI rule); arbiter does not latch the fields.
- DATA:
  - s_r_valid_o[grant] = m_r_valid_i; data/resp/last passed through.
  - m_r_ready_o = s_r_ready_i[grant].
  - On beat handshake with m_r_last_i=1: go to IDLE, rr_ptr = (grant+1) mod N_MST.
  - A new grant can be issued in the cycle after last.
- Requests from non-granted masters see ready=0 and wait; no request is dropped.
- Simultaneous valid from all masters: strict rotation, each served once per N_MST transactions.
- A single requester is re-granted back-to-back at 3-cycle minimum spacing (IDLE, ADDR, DATA).
- m_r_id_i is not used for routing; the single outstanding transaction guarantees the match.
- Zero-cycle ready (m_ar_ready_i high in the first ADDR cycle) is supported.

Optional Feature:
- Macro: AXI_RD_ARB_TIMEOUT_EN.
- Defined:
  - A counter in DATA resets on every R handshake and increments otherwise.
  - On reaching TIMEOUT, the arbiter drives one synthetic beat to the granted master: s_r_valid=1, resp=2'b10 (SLVERR), last=1, data=0, m_r_ready_o=0.
  - On that beat's handshake: go to IDLE, advance rr_ptr.
- Not defined: no counter; DATA waits indefinitely.

Decomposition:
- Shared package: AXI resp constants (OKAY/EXOKAY/SLVERR/DECERR), burst-type constants, state enum {IDLE, ADDR, DATA}.
- One natural sub-module: rr_pick (combinational round-robin priority encoder).
  - Inputs: req vector, rr_ptr.
  - Outputs: grant index, hit flag.
  - Reused by the future write arbiter.

Test Plan:
- Single master 0, addr 0x3000_0000, len 0, R OKAY data 0xDEADBEEF -> m_ar_id=0; master 0 gets 1 beat, last=1; busy_o falls the cycle after.
- Masters 0 and 1 assert in the same cycle after reset -> grant 0 first, then grant 1; ar_ready to master 1 stays 0 until master 0's rlast.
- Master 1 burst len=3 with s_r_ready_i toggling 1,0,1,0 -> exactly 4 beats delivered in order, no loss or duplication, last only on beat 4.
- All masters continuously requesting, N_MST=4 -> grant sequence 0,1,2,3,0,...
- rst_i pulsed in DATA mid-burst -> next cycle all outputs 0, state IDLE, later beats not forwarded.
- With AXI_RD_ARB_TIMEOUT_EN, TIMEOUT=8, slave stalls R after AR -> after 8 cycles master sees resp=2'b10, last=1; arbiter returns to IDLE.
